// File: rtl/vend_pkg.sv
// Shared types and helpers for the multi-product token vending controller.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CREDIT   = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } vend_state_t;

    // Width of a 1-based product index where 0 means "no product".
    function automatic int sel_w(input int num_products);
        return $clog2(num_products + 1);
    endfunction

    // Extract price field i from a packed price vector (up to 8 products x 8 bits).
    function automatic logic [31:0] price_of(input logic [63:0] prices,
                                             input int          price_w,
                                             input int          i);
        logic [63:0] field;
        field = (prices >> (i * price_w)) & ((64'd1 << price_w) - 64'd1);
        return field[31:0];
    endfunction

endpackage

// File: rtl/vend_price_select.sv
// Combinational product arbiter: lowest-index pressed button whose price fits the credit.
module vend_price_select
    import vend_pkg::*;
#(
    parameter int                            NUM_PRODUCTS = 4,
    parameter int                            PRICE_W      = 4,
    parameter logic [NUM_PRODUCTS*PRICE_W-1:0] PRICES     = 16'h4321,
    parameter int                            CREDIT_W     = 8,
    parameter int                            SEL_W        = sel_w(NUM_PRODUCTS)
) (
    input  logic [NUM_PRODUCTS-1:0] button,
    input  logic [CREDIT_W-1:0]     credit,
    output logic                    hit,
    output logic [SEL_W-1:0]        idx,
    output logic [CREDIT_W-1:0]     price
);

    logic [NUM_PRODUCTS-1:0][CREDIT_W-1:0] lane_price;
    logic [NUM_PRODUCTS-1:0]               afford;

    for (genvar g = 0; g < NUM_PRODUCTS; g++) begin : g_lane
        assign lane_price[g] = CREDIT_W'(price_of(64'(PRICES), PRICE_W, g));
        assign afford[g]     = button[g] && (lane_price[g] <= credit);
    end

    // Scan high to low so the lowest affordable index is written last and wins.
    always_comb begin
        hit   = 1'b0;
        idx   = '0;
        price = '0;
        for (int i = NUM_PRODUCTS - 1; i >= 0; i--) begin
            if (afford[i]) begin
                hit   = 1'b1;
                idx   = SEL_W'(i);
                price = lane_price[i];
            end
        end
    end

endmodule

// File: rtl/vend_multi.sv
// Token vending controller: credit accumulation, product dispense and change handshake.
// Define VEND_TIMEOUT_EN to add the dispense watchdog (fault pulse + full refund).
module vend_multi
    import vend_pkg::*;
#(
    parameter int                              NUM_PRODUCTS     = 4,
    parameter int                              PRICE_W          = 4,
    parameter logic [NUM_PRODUCTS*PRICE_W-1:0] PRICES           = 16'h4321,
    parameter int                              CREDIT_W         = 8,
    parameter int                              MAX_CREDIT       = 15,
    parameter int                              DISPENSE_TIMEOUT = 1000,
    localparam int                             SEL_W            = sel_w(NUM_PRODUCTS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    token_in,
    input  logic [NUM_PRODUCTS-1:0] button,
    input  logic                    cancel,
    input  logic                    dispense_done,
    input  logic                    change_ack,
    output logic                    dispense,
    output logic [SEL_W-1:0]        product_sel,
    output logic                    change_valid,
    output logic [CREDIT_W-1:0]     change_tokens,
    output logic [CREDIT_W-1:0]     credit,
    output logic                    token_reject,
    output logic                    dispense_fault
);

    vend_state_t         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] price_q, price_d;
    logic [CREDIT_W-1:0] change_q, change_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                dispense_q, dispense_d;
    logic                cv_q, cv_d;
    logic                rej_q, rej_d;

    logic                ps_hit;
    logic [SEL_W-1:0]    ps_idx;
    logic [CREDIT_W-1:0] ps_price;
    logic [CREDIT_W-1:0] remain;

    vend_price_select #(
        .NUM_PRODUCTS (NUM_PRODUCTS),
        .PRICE_W      (PRICE_W),
        .PRICES       (PRICES),
        .CREDIT_W     (CREDIT_W),
        .SEL_W        (SEL_W)
    ) u_sel (
        .button (button),
        .credit (credit_q),
        .hit    (ps_hit),
        .idx    (ps_idx),
        .price  (ps_price)
    );

    // Selection only happens when price <= credit, so this cannot wrap.
    assign remain = credit_q - price_q;

`ifdef VEND_TIMEOUT_EN
    localparam int CNT_W = $clog2(DISPENSE_TIMEOUT + 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             fault_q, fault_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
            fault_q <= 1'b0;
        end else begin
            tmo_cnt <= (state_q == ST_DISPENSE) ? tmo_cnt + CNT_W'(1) : '0;
            fault_q <= fault_d;
        end
    end

    assign tmo_hit        = (state_q == ST_DISPENSE) && (tmo_cnt == CNT_W'(DISPENSE_TIMEOUT - 1));
    assign dispense_fault = fault_q;
`else
    assign dispense_fault = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            credit_q   <= '0;
            price_q    <= '0;
            change_q   <= '0;
            sel_q      <= '0;
            dispense_q <= 1'b0;
            cv_q       <= 1'b0;
            rej_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            price_q    <= price_d;
            change_q   <= change_d;
            sel_q      <= sel_d;
            dispense_q <= dispense_d;
            cv_q       <= cv_d;
            rej_q      <= rej_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        price_d    = price_q;
        change_d   = change_q;
        sel_d      = sel_q;
        dispense_d = dispense_q;
        cv_d       = cv_q;
        rej_d      = 1'b0;
`ifdef VEND_TIMEOUT_EN
        fault_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (token_in) begin
                    credit_d = CREDIT_W'(1);
                    state_d  = ST_CREDIT;
                end
            end
            ST_CREDIT: begin
                // A token coinciding with a purchase or refund is bounced, not counted.
                if (ps_hit) begin
                    dispense_d = 1'b1;
                    sel_d      = ps_idx + SEL_W'(1);
                    price_d    = ps_price;
                    rej_d      = token_in;
                    state_d    = ST_DISPENSE;
                end else if (cancel) begin
                    cv_d     = 1'b1;
                    change_d = credit_q;
                    rej_d    = token_in;
                    state_d  = ST_CHANGE;
                end else if (token_in) begin
                    if (credit_q < CREDIT_W'(MAX_CREDIT)) credit_d = credit_q + CREDIT_W'(1);
                    else                                  rej_d    = 1'b1;
                end
            end
            ST_DISPENSE: begin
                rej_d = token_in;
                if (dispense_done) begin
                    dispense_d = 1'b0;
                    sel_d      = '0;
                    credit_d   = remain;
                    if (remain == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cv_d     = 1'b1;
                        change_d = remain;
                        state_d  = ST_CHANGE;
                    end
                end
`ifdef VEND_TIMEOUT_EN
                else if (tmo_hit) begin
                    dispense_d = 1'b0;
                    sel_d      = '0;
                    fault_d    = 1'b1;
                    cv_d       = 1'b1;
                    change_d   = credit_q;
                    state_d    = ST_CHANGE;
                end
`endif
            end
            ST_CHANGE: begin
                rej_d = token_in;
                if (change_ack) begin
                    cv_d     = 1'b0;
                    change_d = '0;
                    credit_d = '0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign dispense      = dispense_q;
    assign product_sel   = sel_q;
    assign change_valid  = cv_q;
    assign change_tokens = change_q;
    assign credit        = credit_q;
    assign token_reject  = rej_q;

endmodule

// File: tb/tb_vend_multi.sv
// Directed bench for vend_multi with a transaction-level model checked every cycle.
module tb_vend_multi;

    localparam int          NP   = 4;
    localparam int          PW   = 4;
    localparam int          CW   = 8;
    localparam int          MAXC = 15;
    localparam int          TMO  = 10;
    localparam int          SW   = 3;
    localparam logic [15:0] PR   = 16'h4321;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          token_in = 1'b0;
    logic [NP-1:0] button = '0;
    logic          cancel = 1'b0;
    logic          dispense_done = 1'b0;
    logic          change_ack = 1'b0;
    logic          dispense, change_valid, token_reject, dispense_fault;
    logic [SW-1:0] product_sel;
    logic [CW-1:0] change_tokens, credit;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: coins held, product in flight (1-based, 0 none), pending refund.
    int m_credit, m_sel, m_cv, m_change, m_rej, m_fault, m_tcnt;

    vend_multi #(
        .NUM_PRODUCTS     (NP),
        .PRICE_W          (PW),
        .PRICES           (PR),
        .CREDIT_W         (CW),
        .MAX_CREDIT       (MAXC),
        .DISPENSE_TIMEOUT (TMO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .token_in       (token_in),
        .button         (button),
        .cancel         (cancel),
        .dispense_done  (dispense_done),
        .change_ack     (change_ack),
        .dispense       (dispense),
        .product_sel    (product_sel),
        .change_valid   (change_valid),
        .change_tokens  (change_tokens),
        .credit         (credit),
        .token_reject   (token_reject),
        .dispense_fault (dispense_fault)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic int price(input int i);
        logic [15:0] pv;
        pv = PR;
        return int'(pv[i*PW +: PW]);
    endfunction

    function automatic void m_clear();
        m_credit = 0; m_sel = 0; m_cv = 0; m_change = 0;
        m_rej = 0; m_fault = 0; m_tcnt = 0;
    endfunction

    function automatic void m_step();
        int w;
        m_rej   = 0;
        m_fault = 0;
        if (m_cv != 0) begin
            m_rej = int'(token_in);
            if (change_ack) begin
                m_cv = 0; m_change = 0; m_credit = 0;
            end
        end else if (m_sel != 0) begin
            m_rej = int'(token_in);
            m_tcnt++;
            if (dispense_done) begin
                m_credit = m_credit - price(m_sel - 1);
                m_sel    = 0;
                if (m_credit > 0) begin m_cv = 1; m_change = m_credit; end
            end
`ifdef VEND_TIMEOUT_EN
            else if (m_tcnt == TMO) begin
                m_sel = 0; m_fault = 1; m_cv = 1; m_change = m_credit;
            end
`endif
        end else if (m_credit == 0) begin
            if (token_in) m_credit = 1;
        end else begin
            w = -1;
            for (int i = 0; i < NP; i++)
                if (button[i] && price(i) <= m_credit) begin w = i; break; end
            if (w >= 0) begin
                m_sel = w + 1; m_tcnt = 0; m_rej = int'(token_in);
            end else if (cancel) begin
                m_cv = 1; m_change = m_credit; m_rej = int'(token_in);
            end else if (token_in) begin
                if (m_credit < MAXC) m_credit++;
                else                 m_rej = 1;
            end
        end
    endfunction

    initial begin
        m_clear();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) m_clear();
            else        m_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("dispense",       int'(dispense),       int'(m_sel != 0));
            chk("product_sel",    int'(product_sel),    m_sel);
            chk("change_valid",   int'(change_valid),   m_cv);
            chk("change_tokens",  int'(change_tokens),  m_change);
            chk("credit",         int'(credit),         m_credit);
            chk("token_reject",   int'(token_reject),   m_rej);
            chk("dispense_fault", int'(dispense_fault), m_fault);
        end
    end

    task automatic step(input logic tok, input logic [NP-1:0] btn, input logic can,
                        input logic dn, input logic ack);
        token_in = tok; button = btn; cancel = can; dispense_done = dn; change_ack = ack;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tokens(input int n);
        repeat (n) step(1'b1, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_dispense", int'(dispense), 0);
        chk("rst_credit",   int'(credit), 0);
        chk("rst_cv",       int'(change_valid), 0);
        reset = 1'b1;
        idle(1);

        // exact price: 2 tokens, product 1 (price 2)
        tokens(2);
        chk("t1_credit", int'(credit), 2);
        step(1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
        chk("t1_dispense", int'(dispense), 1);
        chk("t1_sel", int'(product_sel), 2);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("t1_done_disp", int'(dispense), 0);
        chk("t1_done_credit", int'(credit), 0);
        chk("t1_no_change", int'(change_valid), 0);
        step(1'b0, 4'b0001, 1'b1, 1'b0, 1'b1);
        chk("idle_ignores", int'(dispense), 0);

        // change returned: 5 tokens, product 2 (price 3)
        tokens(5);
        step(1'b0, 4'b0100, 1'b0, 1'b0, 1'b0);
        chk("t2_sel", int'(product_sel), 3);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle(3);
        chk("t2_cv_held", int'(change_valid), 1);
        chk("t2_change_held", int'(change_tokens), 2);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("t2_ack_cv", int'(change_valid), 0);
        chk("t2_ack_change", int'(change_tokens), 0);
        chk("t2_ack_credit", int'(credit), 0);

        // unaffordable button ignored; lowest affordable wins; token alongside is bounced
        tokens(1);
        step(1'b0, 4'b1000, 1'b0, 1'b0, 1'b0);
        chk("t3_ignored", int'(dispense), 0);
        chk("t3_credit", int'(credit), 1);
        step(1'b1, 4'b1001, 1'b0, 1'b0, 1'b0);
        chk("t3_sel", int'(product_sel), 1);
        chk("t3_rej", int'(token_reject), 1);
        chk("t3_credit2", int'(credit), 1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("t3_done_credit", int'(credit), 0);

        // credit ceiling
        tokens(15);
        chk("t4_credit15", int'(credit), 15);
        chk("t4_no_rej", int'(token_reject), 0);
        tokens(1);
        chk("t4_rej", int'(token_reject), 1);
        chk("t4_credit_kept", int'(credit), 15);
        idle(1);
        chk("t4_rej_pulse", int'(token_reject), 0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("t4_refund", int'(change_tokens), 15);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle(1);

        // token during dispense
        tokens(3);
        step(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0);
        step(1'b1, '0, 1'b1, 1'b0, 1'b0);
        chk("t5_rej", int'(token_reject), 1);
        chk("t5_credit", int'(credit), 3);
        chk("t5_still_disp", int'(dispense), 1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("t5_change", int'(change_tokens), 2);
        step(1'b1, '0, 1'b0, 1'b0, 1'b1);
        chk("t5_chg_rej", int'(token_reject), 1);
        idle(1);

`ifdef VEND_TIMEOUT_EN
        tokens(1);
        step(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0);
        idle(9);
        chk("tmo_wait", int'(dispense), 1);
        chk("tmo_no_fault", int'(dispense_fault), 0);
        idle(1);
        chk("tmo_fault", int'(dispense_fault), 1);
        chk("tmo_refund", int'(change_tokens), 1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle(1);
`endif

        // cancel with simultaneous token, then async reset while change pending
        tokens(3);
        step(1'b1, '0, 1'b1, 1'b0, 1'b0);
        chk("t6_change", int'(change_tokens), 3);
        chk("t6_rej", int'(token_reject), 1);
        idle(1);
        #2 reset = 1'b0;
        #1;
        chk("arst_cv", int'(change_valid), 0);
        chk("arst_change", int'(change_tokens), 0);
        chk("arst_credit", int'(credit), 0);
        @(negedge clk);
        reset = 1'b1;
        tokens(1);
        chk("arst_restart", int'(credit), 1);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
